// File: rtl/user_ycbcr422_to_444.sv
// user_ycbcr422_to_444: YCbCr 4:2:2 to 4:4:4 upsampler, fixed 4-cycle latency.
//
// Ports:
//   clk, rst_n        single rising-edge clock, async active-low reset
//   ycbcr422_din      {Y, C}; C alternates Cb (even pixel), Cr (odd pixel) within a line
//   ycbcr422_h_sync   horizontal sync, delayed by 4 cycles
//   ycbcr422_v_sync   vertical sync, delayed by 4 cycles
//   ycbcr422_de       active pixel; each contiguous high run is one line
//   ycbcr_dout        {Y, Cr, Cb}, registered, zero whenever ycbcr_de is low
//   ycbcr_h_sync/ycbcr_v_sync/ycbcr_de  delayed syncs and data enable
//
// Three input stages give the output stage one pixel of history (stage 4)
// and two pixels of look-ahead (stages 1 and 2) around the pixel in stage 3.
// That is enough to interpolate odd pixels from the neighbouring pairs. Because
// de is contiguous per line, "neighbour stage has de high" implies
// "same line", so chroma never crosses a line boundary.
module user_ycbcr422_to_444 #(
  parameter int unsigned BIT_PER_SYMBLE = 8,
  parameter int unsigned CHROMA_FILL    = 128
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2*BIT_PER_SYMBLE-1:0] ycbcr422_din,
  input  logic                        ycbcr422_h_sync,
  input  logic                        ycbcr422_v_sync,
  input  logic                        ycbcr422_de,
  output logic [3*BIT_PER_SYMBLE-1:0] ycbcr_dout,
  output logic                        ycbcr_h_sync,
  output logic                        ycbcr_v_sync,
  output logic                        ycbcr_de
);

  localparam int unsigned W = BIT_PER_SYMBLE;
  localparam logic [W-1:0] Fill = W'(CHROMA_FILL);

  // Pixel-index parity; the full index is never needed.
  logic par_q, par_d, odd_in;

  // Stage s is held at index s-1.
  logic [W-1:0] y_q   [3];
  logic [W-1:0] c_q   [3];
  logic         de_q  [3];
  logic         odd_q [3];
  logic         hs_q  [3];
  logic         vs_q  [3];

  // Stage 4: only chroma and de of the pixel just emitted are needed.
  logic [W-1:0] c4_q;
  logic         de4_q;

  logic [3*W-1:0] dout_q, dout_d;
  logic           hs_out_q, vs_out_q, de_out_q;

  logic [W:0]   sum_cb, sum_cr;
  logic [W-1:0] cb, cr;

  assign odd_in = ycbcr422_de & par_q;
  assign par_d  = ycbcr422_de & ~par_q;

  always_comb begin
    // Round-half-up mean of this pair and the next; W+1 bits cannot overflow.
    sum_cb = {1'b0, c4_q}   + {1'b0, c_q[1]} + (W + 1)'(1);
    sum_cr = {1'b0, c_q[2]} + {1'b0, c_q[0]} + (W + 1)'(1);
    cb     = c_q[2];
    cr     = c_q[2];
    if (!odd_q[2]) begin
      // Even pixel 2k: own Cb_k; Cr_k from next pixel, else Cr_(k-1), else fill.
      cb = c_q[2];
      if (de_q[1]) begin
        cr = c_q[1];
      end else if (de4_q) begin
        cr = c4_q;
      end else begin
        cr = Fill;
      end
    end else begin
      // Odd pixel 2k+1: Cb_k is one pixel back, Cr_k is own sample.
      if (de_q[1] && de_q[0]) begin
        cb = sum_cb[W:1];
        cr = sum_cr[W:1];
      end else begin
        cb = c4_q;
        cr = c_q[2];
      end
    end
    dout_d = de_q[2] ? {y_q[2], cr, cb} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        y_q[i]   <= '0;
        c_q[i]   <= '0;
        de_q[i]  <= 1'b0;
        odd_q[i] <= 1'b0;
        hs_q[i]  <= 1'b0;
        vs_q[i]  <= 1'b0;
      end
      c4_q     <= '0;
      de4_q    <= 1'b0;
      dout_q   <= '0;
      hs_out_q <= 1'b0;
      vs_out_q <= 1'b0;
      de_out_q <= 1'b0;
    end else begin
      par_q    <= par_d;
      y_q[0]   <= ycbcr422_din[2*W-1:W];
      c_q[0]   <= ycbcr422_din[W-1:0];
      de_q[0]  <= ycbcr422_de;
      odd_q[0] <= odd_in;
      hs_q[0]  <= ycbcr422_h_sync;
      vs_q[0]  <= ycbcr422_v_sync;
      for (int i = 1; i < 3; i++) begin
        y_q[i]   <= y_q[i-1];
        c_q[i]   <= c_q[i-1];
        de_q[i]  <= de_q[i-1];
        odd_q[i] <= odd_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
      end
      c4_q     <= c_q[2];
      de4_q    <= de_q[2];
      dout_q   <= dout_d;
      hs_out_q <= hs_q[2];
      vs_out_q <= vs_q[2];
      de_out_q <= de_q[2];
    end
  end

  assign ycbcr_dout   = dout_q;
  assign ycbcr_h_sync = hs_out_q;
  assign ycbcr_v_sync = vs_out_q;
  assign ycbcr_de     = de_out_q;

endmodule

// File: doc/user_ycbcr422_to_444.md
USER_YCBCR422_TO_444 -- requirements
Module: user_ycbcr422_to_444

Interface
REQ-001 SHALL provide parameter BIT_PER_SYMBLE, default 8, bits per Y/Cb/Cr symbol; all widths below scale with it.
REQ-002 SHALL provide parameter CHROMA_FILL, default 128, chroma substituted when no Cr sample exists on a line.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ycbcr422_din  input  2*BIT_PER_SYMBLE  {Y, C}; C alternates Cb, Cr per active pixel.
REQ-006 SHALL have port ycbcr422_h_sync  input  1  horizontal sync, passed through.
REQ-007 SHALL have port ycbcr422_v_sync  input  1  vertical sync, passed through.
REQ-008 SHALL have port ycbcr422_de  input  1  active pixel; contiguous high run per line.
REQ-009 SHALL have port ycbcr_dout  output  3*BIT_PER_SYMBLE  {Y[23:16], Cr[15:8], Cb[7:0]} for 8-bit symbols, registered.
REQ-010 SHALL have ports ycbcr_h_sync, ycbcr_v_sync, ycbcr_de  output  1 each  delayed syncs/de, registered.

Function
REQ-011 Pixel index n SHALL count de-high cycles from 0; counter cleared whenever ycbcr422_de is low.
REQ-012 Even n=2k SHALL carry Cb_k; odd n=2k+1 SHALL carry Cr_k; pair k = (Cb_k, Cr_k) is co-sited with pixel 2k.
REQ-013 Output pixel 2k SHALL be {Y_2k, Cr_k, Cb_k} when pixel 2k+1 exists on the line.
REQ-014 Output pixel 2k+1 SHALL be {Y_2k+1, (Cr_k+Cr_k+1+1)>>1, (Cb_k+Cb_k+1+1)>>1} when pixels 2k+2 and 2k+3 both exist.
REQ-015 Output pixel 2k+1 SHALL be {Y_2k+1, Cr_k, Cb_k} when pair k+1 is incomplete (line ends at 2k+1 or 2k+2).
REQ-016 Final even pixel 2k of an odd-length line SHALL be {Y_2k, Cr_k-1, Cb_k}; if k=0, Cr = CHROMA_FILL.
REQ-017 Averaging SHALL use BIT_PER_SYMBLE+1-bit unsigned sum, round-half-up, no overflow; result fits BIT_PER_SYMBLE bits.
REQ-018 Latency SHALL be exactly 4 clk cycles from input to output for data, h_sync, v_sync and de alike.
REQ-019 ycbcr_dout SHALL be 0 on every cycle where ycbcr_de is low.
REQ-020 Line end (de falling) SHALL flush all pending pixels within the fixed latency; no pixel dropped or duplicated.
REQ-021 De gaps shorter than one cycle do not exist; any de-low cycle SHALL terminate the line (next high starts n=0).
REQ-022 Chroma from one line SHALL never be used for pixels of another line.
REQ-023 Block SHALL accept a new pixel every cycle; no backpressure.

Reset
REQ-024 While rst_n low, all outputs and internal pipeline/state registers SHALL be 0.
REQ-025 After rst_n deassertion, outputs SHALL remain 0/inactive until 4 cycles after the first sampled input.
REQ-026 Reset asserted mid-line SHALL discard that line; first de-high after release is pixel 0.

Verification
REQ-027 4-pixel line (16,100),(20,200),(30,110),(40,210) -> {16,200,100},{20,205,105},{30,210,110},{40,210,110}, de high 4 cycles, 4 cycles after input.
REQ-028 3-pixel line (50,60),(51,70),(52,80) -> {50,70,60},{51,70,60},{52,70,80}.
REQ-029 1-pixel line (90,40) -> {90,128,40}; CHROMA_FILL=16 build -> {90,16,40}.
REQ-030 Rounding: pairs Cb 255/254, Cr 0/1 in 4-pixel line -> odd pixel Cb=255, Cr=1; no wrap.
REQ-031 Two back-to-back lines separated by one de-low cycle, line 2 chroma all 200 -> no line-1 chroma on any line-2 output; syncs track de with 4-cycle delay.
REQ-032 rst_n pulsed low at pixel 5 of an 8-pixel line -> outputs 0 immediately; next line output correct from pixel 0.
